// File: rtl/uc_multiciclo_pkg.sv
// Shared types and constants for the microc multi-cycle control unit:
// state encoding, opcode constants and the decoded control word.
package uc_multiciclo_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [5:0] HALT_OPCODE_DEF = 6'b111111;
    localparam logic [1:0] CLS_ALU         = 2'b00;
    localparam logic [5:0] OP_LI           = 6'b010000;
    localparam logic [5:0] OP_J            = 6'b100000;
    localparam logic [5:0] OP_JZ           = 6'b100001;
    localparam logic [5:0] OP_JNZ          = 6'b100010;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we;
        logic       wez;
        logic [2:0] alu_op;
        logic       legal;
    } ctrl_t;

    // Control word with no side effects: PC advances, nothing is written.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c       = '0;
        c.s_inc = 1'b1;
        c.legal = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/uc_multiciclo_if.sv
// Control bus between the microc datapath (master) and the control unit (slave).
interface uc_multiciclo_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       opcode;
    logic             zero;
    logic             run;
    logic             s_inc;
    logic             s_inm;
    logic             we;
    logic             wez;
    logic [2:0]       ALUOp;
    logic             pc_we;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output opcode, zero, run,
        input  s_inc, s_inm, we, wez, ALUOp, pc_we, halted, illegal, instr_count
    );

    modport slave (
        input  opcode, zero, run,
        output s_inc, s_inm, we, wez, ALUOp, pc_we, halted, illegal, instr_count
    );
endinterface

// File: rtl/uc_multiciclo_decoder.sv
// Combinational decode of the latched instruction and the zero flag into
// the EXEC-cycle control word; undefined codes decode to a NOP with legal=0.
module uc_decoder
    import uc_multiciclo_pkg::*;
#(
    parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic [5:0] ir,
    input  logic       zero,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = ctrl_idle();
        // HALT is checked first so a relocated HALT code always wins over a class match.
        if (ir != HALT_OPCODE) begin
            if (ir[5:4] == CLS_ALU) begin
                ctrl.alu_op = ir[2:0];
                ctrl.s_inm  = ir[3];
                ctrl.we     = 1'b1;
                ctrl.wez    = 1'b1;
            end else begin
                case (ir)
                    OP_LI: begin
                        ctrl.s_inm = 1'b1;
                        ctrl.we    = 1'b1;
                    end
                    OP_J:    ctrl.s_inc = 1'b0;
                    OP_JZ:   ctrl.s_inc = ~zero;
                    OP_JNZ:  ctrl.s_inc = zero;
                    default: ctrl.legal = 1'b0;
                endcase
            end
        end
    end

endmodule

// File: rtl/uc_multiciclo.sv
// Two-cycle (FETCH/EXEC) control unit for the microc datapath with HALT/restart,
// a sticky illegal-opcode flag and a saturating retired-instruction counter.
module uc_multiciclo
    import uc_multiciclo_pkg::*;
#(
    parameter int         CNT_W       = 16,
    parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
    input logic            clk,
    input logic            reset,
    uc_multiciclo_if.slave bus
);

    state_t           state;
    logic [5:0]       ir;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt;
    ctrl_t            dec;
    logic             in_exec;

    assign in_exec = (state == S_EXEC);

    uc_decoder #(.HALT_OPCODE(HALT_OPCODE)) u_dec (
        .ir   (ir),
        .zero (bus.zero),
        .ctrl (dec)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_FETCH;
            ir        <= '0;
            illegal_q <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= bus.opcode;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
                    if (!dec.legal) illegal_q <= 1'b1;
                    state <= (ir == HALT_OPCODE) ? S_HALT : S_FETCH;
                end
                S_HALT: begin
                    if (bus.run) state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Outputs depend only on registered state/ir (plus the datapath's registered
    // zero), so an async reset forces the idle word without waiting for clk.
    always_comb begin
        bus.s_inc = 1'b1;
        bus.s_inm = 1'b0;
        bus.we    = 1'b0;
        bus.wez   = 1'b0;
        bus.ALUOp = 3'b000;
        bus.pc_we = 1'b0;
        if (in_exec) begin
            bus.s_inc = dec.s_inc;
            bus.s_inm = dec.s_inm;
            bus.we    = dec.we;
            bus.wez   = dec.wez;
            bus.ALUOp = dec.alu_op;
            bus.pc_we = (ir != HALT_OPCODE);
        end
    end

    assign bus.halted      = (state == S_HALT);
    assign bus.illegal     = illegal_q | (in_exec & ~dec.legal);
    assign bus.instr_count = cnt;

endmodule
